// File: rtl/out_intf_pkg_hdl.sv
// Shared definitions for the out interface TX staging path.
package out_intf_pkg_hdl;

   localparam int unsigned DEFAULT_DATA_WIDTH = 8;
   localparam int unsigned DEFAULT_FRAME_LEN  = 4;

   typedef logic [DEFAULT_DATA_WIDTH-1:0] out_word_t;

   typedef enum logic {
      IDLE,
      IN_FRAME
   } tx_state_t;

endpackage

// File: rtl/out_intf_tx_fifo.sv
// Word buffer for the TX stage: storage, wrapping pointers and occupancy count.
module out_intf_tx_fifo #(
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned FIFO_DEPTH = 4
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          push,
   input  logic [DATA_WIDTH-1:0]         wr_data,
   input  logic                          pop,
   output logic [DATA_WIDTH-1:0]         rd_data,
   output logic                          not_full,
   output logic                          not_empty,
   output logic [$clog2(FIFO_DEPTH):0]   level
);

   localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
   localparam int unsigned LVL_W = PTR_W + 1;

   logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
   logic [PTR_W-1:0]      wr_ptr;
   logic [PTR_W-1:0]      rd_ptr;

   always_ff @(posedge clk) begin
      if (push)
         mem[wr_ptr] <= wr_data;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (push)
            wr_ptr <= wr_ptr + 1'b1;
         if (pop)
            rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   level <= level + 1'b1;
            2'b01:   level <= level - 1'b1;
            default: level <= level;
         endcase
      end
   end

   assign rd_data   = mem[rd_ptr];
   assign not_full  = (level != LVL_W'(FIFO_DEPTH));
   assign not_empty = (level != '0);

endmodule

// File: rtl/out_intf_tx_stage.sv
// Out interface TX stage: buffers core words and emits fixed-length SOP/EOP frames.
// Optional even-parity output enabled by defining OUT_INTF_PARITY_EN.
module out_intf_tx_stage
   import out_intf_pkg_hdl::*;
#(
   parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH,
   parameter int unsigned FIFO_DEPTH = 4,
   parameter int unsigned FRAME_LEN  = DEFAULT_FRAME_LEN
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          in_valid,
   output logic                          in_ready,
   input  logic [DATA_WIDTH-1:0]         in_data,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic [DATA_WIDTH-1:0]         out_data,
   output logic                          out_sop,
   output logic                          out_eop,
`ifdef OUT_INTF_PARITY_EN
   output logic                          out_parity,
`endif
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
   output logic [15:0]                   frame_count
);

   localparam int unsigned IDX_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;

   tx_state_t             state_q, state_d;
   logic [IDX_W-1:0]      word_idx_q, word_idx_d;
   logic [15:0]           frame_count_q, frame_count_d;
   logic                  push, pop, fifo_nempty, last_word;
   logic [DATA_WIDTH-1:0] head;

   out_intf_tx_fifo #(
      .DATA_WIDTH (DATA_WIDTH),
      .FIFO_DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (push),
      .wr_data   (in_data),
      .pop       (pop),
      .rd_data   (head),
      .not_full  (in_ready),
      .not_empty (fifo_nempty),
      .level     (fifo_level)
   );

   assign push      = in_valid && in_ready;
   assign pop       = out_valid && out_ready;
   assign last_word = (word_idx_q == IDX_W'(FRAME_LEN - 1));

   // Head is zeroed while empty so stale RAM contents never reach the port.
   assign out_valid   = fifo_nempty;
   assign out_data    = out_valid ? head : '0;
   assign out_sop     = out_valid && (word_idx_q == '0);
   assign out_eop     = out_valid && last_word;
   assign frame_count = frame_count_q;

`ifdef OUT_INTF_PARITY_EN
   assign out_parity = ^out_data;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= IDLE;
         word_idx_q    <= '0;
         frame_count_q <= '0;
      end else begin
         state_q       <= state_d;
         word_idx_q    <= word_idx_d;
         frame_count_q <= frame_count_d;
      end
   end

   always_comb begin
      state_d       = state_q;
      word_idx_d    = word_idx_q;
      frame_count_d = frame_count_q;
      if (pop) begin
         word_idx_d = last_word ? '0 : word_idx_q + 1'b1;
         if (out_eop)
            frame_count_d = frame_count_q + 16'd1;
      end
      case (state_q)
         IDLE:     if (pop && (FRAME_LEN > 1)) state_d = IN_FRAME;
         IN_FRAME: if (pop && out_eop)         state_d = IDLE;
         default:                              state_d = IDLE;
      endcase
   end

endmodule

// File: tb/tb_out_intf_tx_stage.sv
// Scoreboard bench for out_intf_tx_stage: FRAME_LEN=4 and FRAME_LEN=1 instances.
module tb_out_intf_tx_stage;

   localparam int unsigned FL0 = 4;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic        in_valid, in_ready, out_valid, out_ready, out_sop, out_eop;
   logic [7:0]  in_data, out_data;
   logic [2:0]  fifo_level;
   logic [15:0] frame_count;
   logic        in_valid_1, in_ready_1, out_valid_1, out_ready_1, out_sop_1, out_eop_1;
   logic [7:0]  in_data_1, out_data_1;
   logic [2:0]  fifo_level_1;
   logic [15:0] frame_count_1;
`ifdef OUT_INTF_PARITY_EN
   logic        out_parity, out_parity_1;
`endif

   out_intf_tx_stage #(.DATA_WIDTH(8), .FIFO_DEPTH(4), .FRAME_LEN(FL0)) u_dut0 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_sop(out_sop),
      .out_eop(out_eop),
`ifdef OUT_INTF_PARITY_EN
      .out_parity(out_parity),
`endif
      .fifo_level(fifo_level), .frame_count(frame_count));

   out_intf_tx_stage #(.DATA_WIDTH(8), .FIFO_DEPTH(4), .FRAME_LEN(1)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid_1), .in_ready(in_ready_1), .in_data(in_data_1),
      .out_valid(out_valid_1), .out_ready(out_ready_1), .out_data(out_data_1), .out_sop(out_sop_1),
      .out_eop(out_eop_1),
`ifdef OUT_INTF_PARITY_EN
      .out_parity(out_parity_1),
`endif
      .fifo_level(fifo_level_1), .frame_count(frame_count_1));

   typedef struct packed {
      logic [7:0] data;
      logic       sop;
      logic       eop;
   } exp_t;

   exp_t        sb0[$], sb1[$];
   exp_t        e0, e1;
   int unsigned pos0 = 0;
   int unsigned pops0 = 0;
   logic [15:0] fc0 = '0, fc1 = '0;
   int          n_vec = 0, n_err = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Expected words are queued on acceptance and compared when popped.
   always @(negedge clk) begin
      if (!rst_n) begin
         sb0.delete();
         pos0 = 0;
         fc0  = '0;
      end else begin
         check("d0_frame_count", frame_count, fc0);
         if (out_valid && out_ready) begin
            pops0++;
            if (sb0.size() == 0) begin
               check("d0_sb_underflow", 1, 0);
            end else begin
               e0 = sb0.pop_front();
               check("d0_data", out_data, e0.data);
               check("d0_sop", out_sop, e0.sop);
               check("d0_eop", out_eop, e0.eop);
`ifdef OUT_INTF_PARITY_EN
               check("d0_parity", out_parity, ^e0.data);
`endif
               if (e0.eop) fc0 = fc0 + 16'd1;
            end
         end
         if (in_valid && in_ready) begin
            sb0.push_back('{data: in_data, sop: (pos0 == 0), eop: (pos0 == FL0 - 1)});
            pos0 = (pos0 == FL0 - 1) ? 0 : pos0 + 1;
         end
      end
   end

   always @(negedge clk) begin
      if (!rst_n) begin
         sb1.delete();
         fc1 = '0;
      end else begin
         check("d1_frame_count", frame_count_1, fc1);
         if (out_valid_1 && out_ready_1) begin
            if (sb1.size() == 0) begin
               check("d1_sb_underflow", 1, 0);
            end else begin
               e1 = sb1.pop_front();
               check("d1_data", out_data_1, e1.data);
               check("d1_sop", out_sop_1, e1.sop);
               check("d1_eop", out_eop_1, e1.eop);
`ifdef OUT_INTF_PARITY_EN
               check("d1_parity", out_parity_1, ^e1.data);
`endif
               if (e1.eop) fc1 = fc1 + 16'd1;
            end
         end
         if (in_valid_1 && in_ready_1)
            sb1.push_back('{data: in_data_1, sop: 1'b1, eop: 1'b1});
      end
   end

   // Holds in_valid high until accepted; returns 1 ns after the accepting edge.
   task automatic send0(input logic [7:0] d);
      in_valid = 1'b1;
      in_data  = d;
      for (int i = 0; i < 64; i++) begin
         @(negedge clk);
         if (in_ready) begin
            @(posedge clk);
            #1;
            return;
         end
      end
      check("send0_timeout", 0, 1);
      in_valid = 1'b0;
   endtask

   task automatic drain0();
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (sb0.size() == 0 && !out_valid) begin
            @(posedge clk);
            #1;
            return;
         end
      end
      check("drain0_timeout", 0, 1);
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   int unsigned pops_start;

   initial begin
      in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
      in_valid_1 = 1'b0; in_data_1 = '0; out_ready_1 = 1'b1;

      // Reset values
      @(negedge clk);
      check("rst_in_ready", in_ready, 1);
      check("rst_out_valid", out_valid, 0);
      check("rst_sop", out_sop, 0);
      check("rst_eop", out_eop, 0);
      check("rst_out_data", out_data, 0);
      check("rst_level", fifo_level, 0);
      check("rst_frame_count", frame_count, 0);
      step(2);
      rst_n = 1'b1;
      step(1);

      // One frame at full rate
      send0(8'h11);
      check("latency_out_valid", out_valid, 1);
      check("latency_out_data", out_data, 8'h11);
      pops_start = pops0;
      send0(8'h22);
      send0(8'h33);
      send0(8'h44);
      check("throughput", pops0 - pops_start, 3);
      in_valid = 1'b0;
      drain0();
      check("frame1_count", frame_count, 1);

      // Backpressure into a full FIFO
      out_ready = 1'b0;
      send0(8'h51);
      send0(8'h52);
      send0(8'h53);
      send0(8'h54);
      check("full_in_ready", in_ready, 0);
      check("full_level", fifo_level, 4);
      in_data = 8'h55;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("bp_in_ready", in_ready, 0);
         check("bp_out_data", out_data, 8'h51);
         check("bp_sop", out_sop, 1);
      end
      @(posedge clk);
      #1;
      out_ready = 1'b1;
      send0(8'h55);
      in_valid = 1'b0;
      drain0();

      // Simultaneous push and pop at level 2
      out_ready = 1'b0;
      send0(8'h61);
      send0(8'h62);
      out_ready = 1'b1;
      for (int i = 0; i < 10; i++) begin
         in_data = 8'h70 + 8'(i);
         @(negedge clk);
         check("pp_level", fifo_level, 2);
         check("pp_in_ready", in_ready, 1);
         check("pp_out_valid", out_valid, 1);
         @(posedge clk);
         #1;
      end
      in_valid = 1'b0;
      drain0();

      // Reset mid-frame with words still buffered
      for (int i = 0; i < 8 && pos0 != 0; i++)
         send0(8'hC0 + 8'(i));
      send0(8'h81);
      send0(8'h82);
      in_valid = 1'b0;
      step(2);
      out_ready = 1'b0;
      send0(8'h83);
      send0(8'h84);
      in_valid = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      check("mrst_in_ready", in_ready, 1);
      check("mrst_out_valid", out_valid, 0);
      check("mrst_sop", out_sop, 0);
      check("mrst_eop", out_eop, 0);
      check("mrst_out_data", out_data, 0);
      check("mrst_level", fifo_level, 0);
      check("mrst_frame_count", frame_count, 0);
      @(negedge clk);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      out_ready = 1'b1;
      send0(8'h91);
      in_valid = 1'b0;
      check("post_rst_sop", out_sop, 1);
      drain0();

      // FRAME_LEN=1: every word is a full frame
      in_valid_1 = 1'b1;
      for (int i = 0; i < 3; i++) begin
         in_data_1 = 8'hA0 + 8'(i);
         step(1);
      end
      in_valid_1 = 1'b0;
      step(3);
      check("fl1_frame_count", frame_count_1, 3);
      #1;
      force u_dut1.frame_count_q = 16'hFFFF;
      fc1 = 16'hFFFF;
      #1;
      release u_dut1.frame_count_q;
      step(1);
      in_valid_1 = 1'b1;
      in_data_1  = 8'hB0;
      step(1);
      in_valid_1 = 1'b0;
      step(3);
      check("fl1_wrap", frame_count_1, 16'h0000);

`ifdef OUT_INTF_PARITY_EN
      out_ready = 1'b0;
      send0(8'h07);
      in_valid = 1'b0;
      check("parity_07", out_parity, 1);
      out_ready = 1'b1;
      drain0();
      check("parity_idle", out_parity, 0);
      out_ready = 1'b0;
      send0(8'h03);
      in_valid = 1'b0;
      check("parity_03", out_parity, 0);
      out_ready = 1'b1;
      drain0();
`endif

      check("sb0_empty", sb0.size(), 0);
      check("sb1_empty", sb1.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
